// File: rtl/dvi_test_pattern_gen.sv
// Raster test-pattern pixel source for the DVI output streamer.
// Bars, animated gray ramp, checkerboard and border, active area only.
module dvi_test_pattern_gen #(
    parameter int          H_ACTIVE_COUNT = 800,
    parameter int          V_ACTIVE_COUNT = 600,
    parameter int          CHECKER_LOG2   = 5,
    parameter logic [23:0] SOLID_RGB      = 24'h0000FF
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEnable,
    input  logic [1:0]  iPatternSel,
    input  logic        iReady,
    output logic        oValid,
    output logic [23:0] oPixel,
    output logic        oSof,
    output logic        oEol,
    output logic [7:0]  oFrameCount
);

    localparam int BAR_W = H_ACTIVE_COUNT / 8;
    localparam int XW0   = $clog2(H_ACTIVE_COUNT);
    localparam int YW0   = $clog2(V_ACTIVE_COUNT);
    localparam int XW    = (XW0 > CHECKER_LOG2) ? XW0 : CHECKER_LOG2 + 1;
    localparam int YW    = (YW0 > CHECKER_LOG2) ? YW0 : CHECKER_LOG2 + 1;
    localparam int BW    = $clog2(BAR_W + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, stateNext;
    logic [XW-1:0] x, xNext;
    logic [YW-1:0] y, yNext;
    logic [BW-1:0] barCnt, barCntNext;
    logic [2:0]    barIdx, barIdxNext;
    logic [1:0]    sel, selNext;
    logic [7:0]    countNext;
    logic [7:0]    ramp;
    logic [23:0]   pixelNext;
    logic          validNext;
    logic          load;
    logic          advance;
    logic          lastX;
    logic          lastY;

    assign lastX = (x == XW'(H_ACTIVE_COUNT - 1));
    assign lastY = (y == YW'(V_ACTIVE_COUNT - 1));

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        validNext  = oValid;
        countNext  = oFrameCount;
        load       = 1'b0;
        advance    = 1'b0;
        xNext      = x;
        yNext      = y;
        barCntNext = barCnt;
        barIdxNext = barIdx;
        selNext    = sel;
        unique case (state)
            IDLE: begin
                if (iEnable) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (oValid && iReady) begin
                    if (lastX && lastY) begin
                        countNext = oFrameCount + 8'd1;
                        if (iEnable) begin
                            load = 1'b1;
                        end else begin
                            stateNext = IDLE;
                            validNext = 1'b0;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        if (load) begin
            xNext      = '0;
            yNext      = '0;
            barCntNext = '0;
            barIdxNext = '0;
            selNext    = iPatternSel;
            validNext  = 1'b1;
        end else if (advance) begin
            if (lastX) begin
                xNext      = '0;
                yNext      = y + YW'(1);
                barCntNext = '0;
                barIdxNext = '0;
            end else begin
                xNext = x + XW'(1);
                // Bar index steps every BAR_W pixels and saturates on black.
                if (barCnt == BW'(BAR_W - 1)) begin
                    barCntNext = '0;
                    if (barIdx != 3'd7) barIdxNext = barIdx + 3'd1;
                end else begin
                    barCntNext = barCnt + BW'(1);
                end
            end
        end

        // Ramp uses the post-increment count so a new frame starts shifted.
        ramp = 8'(xNext) + countNext;
        unique case (selNext)
            2'd0: pixelNext = {{8{~barIdxNext[1]}},
                               {8{~barIdxNext[2]}},
                               {8{~barIdxNext[0]}}};
            2'd1: pixelNext = {ramp, ramp, ramp};
            2'd2: pixelNext = (xNext[CHECKER_LOG2] ^ yNext[CHECKER_LOG2])
                              ? 24'hFFFFFF : 24'h000000;
            default: pixelNext =
                (xNext == '0 || xNext == XW'(H_ACTIVE_COUNT - 1) ||
                 yNext == '0 || yNext == YW'(V_ACTIVE_COUNT - 1))
                ? 24'hFFFFFF : SOLID_RGB;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            x           <= '0;
            y           <= '0;
            barCnt      <= '0;
            barIdx      <= '0;
            sel         <= '0;
            oValid      <= 1'b0;
            oPixel      <= '0;
            oSof        <= 1'b0;
            oEol        <= 1'b0;
            oFrameCount <= '0;
        end else begin
            x           <= xNext;
            y           <= yNext;
            barCnt      <= barCntNext;
            barIdx      <= barIdxNext;
            sel         <= selNext;
            oValid      <= validNext;
            oFrameCount <= countNext;
            if (load || advance) begin
                oPixel <= pixelNext;
                oSof   <= (xNext == '0) && (yNext == '0);
                oEol   <= (xNext == XW'(H_ACTIVE_COUNT - 1));
            end
        end
    end

endmodule
